// File: rtl/mmio_timer.sv
// Memory-mapped timer/compare responder on the core data bus: prescaled counter,
// compare match with level IRQ, overflow flag. Optional macro: MMIO_TIMER_AUTORELOAD_EN.
module mmio_timer #(
    parameter int          WIDTH     = 32,
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          PRESC_W   = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             mem_we_i,
    input  logic [WIDTH-1:0] mem_addr_i,
    input  logic [WIDTH-1:0] mem_data_i,
    output logic [WIDTH-1:0] mem_data_o,
    output logic             irq_o
);

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_COUNT    = 3'd1;
    localparam logic [2:0] REG_COMPARE  = 3'd2;
    localparam logic [2:0] REG_STATUS   = 3'd3;
    localparam logic [2:0] REG_PRESCALE = 3'd4;

    logic               en;
    logic               irq_en;
    logic [WIDTH-1:0]   count;
    logic [WIDTH-1:0]   compare;
    logic               match;
    logic               ovf;
    logic [PRESC_W-1:0] prescale;
    logic [PRESC_W-1:0] presc_cnt;

    logic               hit;
    logic [2:0]         sel;
    logic               wr_ctrl;
    logic               wr_count;
    logic               wr_compare;
    logic               wr_status;
    logic               wr_prescale;
    logic               tick;
    logic               cnt_match;
    logic               match_set;
    logic               ovf_set;
    logic [WIDTH-1:0]   count_next;
    logic [WIDTH-1:0]   rdata;
    logic               unused_addr_bits;

    // Only full-word accesses exist, so the byte-lane bits carry no information.
    assign unused_addr_bits = ^mem_addr_i[1:0];

    assign hit         = (mem_addr_i[31:5] == BASE_ADDR[31:5]);
    assign sel         = mem_addr_i[4:2];
    assign wr_ctrl     = mem_we_i && hit && (sel == REG_CTRL);
    assign wr_count    = mem_we_i && hit && (sel == REG_COUNT);
    assign wr_compare  = mem_we_i && hit && (sel == REG_COMPARE);
    assign wr_status   = mem_we_i && hit && (sel == REG_STATUS);
    assign wr_prescale = mem_we_i && hit && (sel == REG_PRESCALE);

    assign tick      = en && (presc_cnt == prescale);
    assign cnt_match = (count == compare);
    assign match_set = tick && cnt_match;
    // A COUNT write replaces the increment, so no wrap can happen on that edge.
    assign ovf_set   = tick && !wr_count && (count == '1);

`ifdef MMIO_TIMER_AUTORELOAD_EN
    assign count_next = cnt_match ? '0 : count + WIDTH'(1);
`else
    assign count_next = count + WIDTH'(1);
`endif

    always_comb begin
        rdata = '0;
        case (sel)
            REG_CTRL:     rdata = {{(WIDTH-2){1'b0}}, irq_en, en};
            REG_COUNT:    rdata = count;
            REG_COMPARE:  rdata = compare;
            REG_STATUS:   rdata = {{(WIDTH-2){1'b0}}, ovf, match};
            REG_PRESCALE: rdata = {{(WIDTH-PRESC_W){1'b0}}, prescale};
            default:      rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            en         <= 1'b0;
            irq_en     <= 1'b0;
            count      <= '0;
            compare    <= '0;
            match      <= 1'b0;
            ovf        <= 1'b0;
            prescale   <= '0;
            presc_cnt  <= '0;
            mem_data_o <= '0;
        end else begin
            mem_data_o <= hit ? rdata : '0;

            if (wr_ctrl) begin
                en     <= mem_data_i[0];
                irq_en <= mem_data_i[1];
            end
            if (wr_compare) compare <= mem_data_i;
            if (wr_prescale) prescale <= mem_data_i[PRESC_W-1:0];

            if (wr_count || wr_prescale) presc_cnt <= '0;
            else if (tick)               presc_cnt <= '0;
            else if (en)                 presc_cnt <= presc_cnt + PRESC_W'(1);

            if (wr_count)  count <= mem_data_i;
            else if (tick) count <= count_next;

            // Hardware set takes priority over a same-cycle write-1-to-clear.
            match <= match_set || (match && !(wr_status && mem_data_i[0]));
            ovf   <= ovf_set   || (ovf   && !(wr_status && mem_data_i[1]));
        end
    end

    assign irq_o = match && irq_en;

endmodule

// File: tb/tb_mmio_timer.sv
// Directed bench for mmio_timer: a register-level model predicts read data and irq
// every cycle; literal expectations pin the model at key points.
module tb_mmio_timer;

    localparam logic [31:0] BASE = 32'h0000_1000;
    localparam logic [31:0] A_CTRL = BASE + 32'h00;
    localparam logic [31:0] A_COUNT = BASE + 32'h04;
    localparam logic [31:0] A_CMP = BASE + 32'h08;
    localparam logic [31:0] A_STAT = BASE + 32'h0C;
    localparam logic [31:0] A_PRESC = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_data_i;
    logic [31:0] mem_data_o;
    logic        irq_o;

    int n_vec = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    // Model state: architectural registers plus enabled-cycle count since the last clear.
    bit          m_en, m_irqen, m_match, m_ovf;
    logic [31:0] m_count, m_cmp;
    logic [15:0] m_presc;
    longint      m_phase;
    logic [31:0] exp_rd;
    bit          exp_irq;

    mmio_timer dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .mem_we_i(mem_we_i),
        .mem_addr_i(mem_addr_i),
        .mem_data_i(mem_data_i),
        .mem_data_o(mem_data_o),
        .irq_o(irq_o)
    );

    always #5 clk = ~clk;

    function automatic bit m_hit(input logic [31:0] a);
        return (a >> 5) == (BASE >> 5);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_hit(a)) return 32'h0;
        case (a[4:2])
            3'd0: return {30'h0, m_irqen, m_en};
            3'd1: return m_count;
            3'd2: return m_cmp;
            3'd3: return {30'h0, m_ovf, m_match};
            3'd4: return {16'h0, m_presc};
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_en = 0; m_irqen = 0; m_match = 0; m_ovf = 0;
        m_count = 0; m_cmp = 0; m_presc = 0; m_phase = 0;
        exp_rd = 0; exp_irq = 0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, req);
        end
    endtask

    // One bus cycle: drive, predict, clock, commit prediction.
    task automatic cyc(input bit we, input logic [31:0] a, input logic [31:0] d);
        logic [31:0] rd, n_count;
        bit hit, tick, wc, wp, n_match, n_ovf, set_m;
        longint period;
        mem_we_i = we; mem_addr_i = a; mem_data_i = d;
        rd = m_read(a);
        hit = m_hit(a);
        period = longint'(m_presc) + 1;
        tick = m_en && ((m_phase % period) == period - 1);
        wc = we && hit && (a[4:2] == 3'd1);
        wp = we && hit && (a[4:2] == 3'd4);
        set_m = tick && (m_count == m_cmp);
        n_count = m_count;
        if (wc) n_count = d;
        else if (tick) begin
`ifdef MMIO_TIMER_AUTORELOAD_EN
            n_count = set_m ? 32'h0 : m_count + 1;
`else
            n_count = m_count + 1;
`endif
        end
        n_match = m_match;
        n_ovf = m_ovf;
        if (we && hit && a[4:2] == 3'd3) begin
            if (d[0]) n_match = 0;
            if (d[1]) n_ovf = 0;
        end
        if (set_m) n_match = 1;
        if (tick && !wc && m_count == 32'hFFFF_FFFF) n_ovf = 1;
        @(posedge clk);
        #1;
        if (wc || wp) m_phase = 0;
        else if (m_en) m_phase = m_phase + 1;
        if (we && hit && a[4:2] == 3'd0) begin m_en = d[0]; m_irqen = d[1]; end
        if (we && hit && a[4:2] == 3'd2) m_cmp = d;
        if (wp) m_presc = d[15:0];
        m_count = n_count;
        m_match = n_match;
        m_ovf = n_ovf;
        exp_rd = rd;
        exp_irq = m_match && m_irqen;
        mem_we_i = 1'b0;
    endtask

    task automatic expect_rd(input logic [31:0] a, input logic [31:0] v, input string nm);
        cyc(1'b0, a, 32'h0);
        @(negedge clk);
        chk(nm, mem_data_o, v);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            chk("model_rdata", mem_data_o, exp_rd);
            chk("model_irq", {31'h0, irq_o}, {31'h0, exp_irq});
        end
    end

    initial begin
        int n;
        logic [31:0] c;
        rst_i = 1'b1; mem_we_i = 1'b0; mem_addr_i = 32'h0; mem_data_i = 32'h0;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("rst_rdata", mem_data_o, 32'h0);
            chk("rst_irq", {31'h0, irq_o}, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_on = 1'b1;

        for (int i = 0; i < 5; i++) expect_rd(BASE + 32'(i * 4), 32'h0, "post_rst_reg");

        // Read latency, unmapped and out-of-window accesses
        cyc(1, A_CMP, 32'h31);
        expect_rd(A_CMP, 32'h31, "cmp_readback");
        cyc(1, BASE + 32'h18, 32'hFF);
        expect_rd(BASE + 32'h18, 32'h0, "unmapped_rd");
        expect_rd(32'h0000_0040, 32'h0, "ram_space_rd");
        cyc(1, 32'h0000_0008, 32'h77);
        expect_rd(A_CMP, 32'h31, "nohit_write_ignored");
        cyc(1, A_CMP, 32'h55);
        @(negedge clk);
        chk("same_cycle_old_value", mem_data_o, 32'h31);
        expect_rd(A_CMP, 32'h55, "cmp_new_value");
        expect_rd(A_CMP + 32'h1, 32'h55, "low_addr_bits_ignored");

        // Prescale by 4
        cyc(1, A_PRESC, 32'hABCD_0003);
        cyc(1, A_COUNT, 32'h0);
        cyc(1, A_CTRL, 32'h1);
        repeat (40) cyc(0, A_COUNT, 0);
        chk("model_presc_count", m_count, 32'd10);
        expect_rd(A_COUNT, 32'd10, "presc_count");
        expect_rd(A_PRESC, 32'h3, "presc_upper_zero");
        cyc(1, A_CTRL, 32'h0);
        repeat (8) cyc(0, A_COUNT, 0);
        expect_rd(A_COUNT, 32'd10, "en0_holds");

        // Compare match and interrupt
        cyc(1, A_PRESC, 32'h0);
        cyc(1, A_CMP, 32'd5);
        cyc(1, A_COUNT, 32'h0);
        cyc(1, A_STAT, 32'h3);
        cyc(1, A_CTRL, 32'h3);
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            cyc(0, A_STAT, 0);
            @(negedge clk);
            if (irq_o === 1'b1) begin n = i; break; end
        end
        chk("irq_latency", 32'(n), 32'd6);
        chk("model_match", {31'h0, m_match}, 32'h1);
        c = m_count;
        cyc(1, A_STAT, 32'h1);
        @(negedge clk);
        chk("w1c_clears_irq", {31'h0, irq_o}, 32'h0);
        cyc(1, A_CMP, c + 32'd4);
        cyc(0, A_STAT, 0);
        cyc(0, A_STAT, 0);
        cyc(1, A_STAT, 32'h1);
        @(negedge clk);
        chk("set_wins_over_w1c", {31'h0, irq_o}, 32'h1);
        cyc(1, A_CTRL, 32'h2);
        cyc(1, A_STAT, 32'h1);
        @(negedge clk);
        chk("irq_cleared", {31'h0, irq_o}, 32'h0);

        // Overflow and COUNT write priority
        cyc(1, A_CTRL, 32'h0);
        cyc(1, A_CMP, 32'h100);
        cyc(1, A_STAT, 32'h3);
        cyc(1, A_COUNT, 32'hFFFF_FFFE);
        cyc(1, A_CTRL, 32'h1);
        cyc(0, A_COUNT, 0);
        cyc(0, A_COUNT, 0);
        chk("model_wrap", m_count, 32'h0);
        expect_rd(A_COUNT, 32'h0, "count_wrapped");
        expect_rd(A_STAT, 32'h2, "ovf_set");
        cyc(1, A_COUNT, 32'd7);
        expect_rd(A_COUNT, 32'd7, "count_write_wins");
        cyc(1, A_STAT, 32'h2);
        expect_rd(A_STAT, 32'h0, "ovf_w1c");

        // Asynchronous reset mid-count
        cyc(0, A_COUNT, 0);
        @(negedge clk);
        chk("pre_rst_nonzero", {31'h0, (mem_data_o != 32'h0)}, 32'h1);
        chk_on = 1'b0;
        #2;
        rst_i = 1'b1;
        #1;
        chk("async_rst_rdata", mem_data_o, 32'h0);
        chk("async_rst_irq", {31'h0, irq_o}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        chk_on = 1'b1;
        expect_rd(A_COUNT, 32'h0, "count_after_rst");
        expect_rd(A_CTRL, 32'h0, "ctrl_after_rst");

`ifdef MMIO_TIMER_AUTORELOAD_EN
        // Periodic reload: COMPARE=4, PRESCALE=1
        cyc(1, A_CMP, 32'd4);
        cyc(1, A_PRESC, 32'd1);
        cyc(1, A_COUNT, 32'h0);
        cyc(1, A_CTRL, 32'h1);
        repeat (20) cyc(0, A_COUNT, 0);
        chk("ar_model_count", m_count, 32'h0);
        expect_rd(A_COUNT, 32'h0, "ar_count_period");
        expect_rd(A_STAT, 32'h1, "ar_match_no_ovf");
`endif

        chk_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
